// File: rtl/bn_leaky_relu_stage_if.sv
// Stream bundle between batch norm, the leaky-ReLU stage and its consumer.
// The slave modport is the stage; the master modport is upstream plus downstream.
interface bn_leaky_relu_stage_if #(
    parameter int DATA_WIDTH = 16,
    parameter int size       = 8,
    parameter int CNT_W      = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_WIDTH*size-1:0] x;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_WIDTH*size-1:0] Out;
    logic                       out_last;
    logic [CNT_W-1:0]           beat_cnt;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, Out, out_last, beat_cnt
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, Out, out_last, beat_cnt
    );
endinterface

// File: rtl/bn_leaky_relu_stage.sv
// FP16 leaky ReLU (slope 2^-SHIFT) over a packed lane vector: 2-stage stallable
// pipeline with valid/ready handshake and a per-frame beat counter.
module bn_lrelu_lane #(
    parameter int SHIFT = 3
) (
    input  logic [15:0] x,
    output logic [1:0]  cls,
    output logic [3:0]  sh,
    input  logic [15:0] raw_q,
    input  logic [1:0]  cls_q,
    input  logic [3:0]  sh_q,
    output logic [15:0] y
);
    localparam logic [1:0] C_PASS = 2'd0;
    localparam logic [1:0] C_NORM = 2'd1;
    localparam logic [1:0] C_SUBN = 2'd2;
    localparam logic [4:0] SH5    = 5'(SHIFT);

    logic [4:0]  e;
    logic [10:0] mant_ext;

    assign e = x[14:10];

    // Stage 1: classify and precompute the denormalising shift amount.
    always_comb begin
        cls = C_PASS;
        sh  = '0;
        if (x[15] && e != 5'h1f) begin
            if (e > SH5) begin
                cls = C_NORM;
            end else if (e != 5'd0) begin
                cls = C_SUBN;
                sh  = 4'(SH5 - e + 5'd1);
            end else if (x[9:0] != 10'd0) begin
                cls = C_SUBN;
                sh  = 4'(SH5);
            end
        end
    end

    // Stage 2: implicit one restored only for normal inputs; shift truncates.
    assign mant_ext = {raw_q[14:10] != 5'd0, raw_q[9:0]};

    always_comb begin
        case (cls_q)
            C_NORM:  y = {1'b1, raw_q[14:10] - SH5, raw_q[9:0]};
            C_SUBN:  y = {1'b1, 5'd0, 10'(mant_ext >> sh_q)};
            default: y = raw_q;
        endcase
    end
endmodule

module bn_leaky_relu_stage #(
    parameter int DATA_WIDTH  = 16,
    parameter int size        = 8,
    parameter int SHIFT       = 3,
    parameter int FRAME_BEATS = 64,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               reset,
    bn_leaky_relu_stage_if.slave io
);
    localparam int STAGES = 2;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BEATS - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] raw;
        logic [1:0]            cls;
        logic [3:0]            sh;
    } s1_t;

    s1_t [size-1:0]                   s1_q;
    logic [size-1:0][1:0]             cls_d;
    logic [size-1:0][3:0]             sh_d;
    logic [size-1:0][DATA_WIDTH-1:0]  y;
    logic [size-1:0][DATA_WIDTH-1:0]  out_q;
    logic [STAGES:1]                  vld_pipe;
    logic [CNT_W-1:0]                 cnt_q;
    logic                             en;
    logic                             fire_out;

    assign en       = !vld_pipe[STAGES] || io.out_ready;
    assign fire_out = vld_pipe[STAGES] && io.out_ready;

    for (genvar i = 0; i < size; i++) begin : g_lane
        bn_lrelu_lane #(.SHIFT(SHIFT)) u_lane (
            .x     (io.x[DATA_WIDTH*i +: DATA_WIDTH]),
            .cls   (cls_d[i]),
            .sh    (sh_d[i]),
            .raw_q (s1_q[i].raw),
            .cls_q (s1_q[i].cls),
            .sh_q  (s1_q[i].sh),
            .y     (y[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
        end else begin
            // One global enable: both stages move together or hold together.
            if (en) begin
                vld_pipe <= {vld_pipe[STAGES-1:1], io.in_valid};
                if (io.in_valid) begin
                    for (int i = 0; i < size; i++) begin
                        s1_q[i].raw <= io.x[DATA_WIDTH*i +: DATA_WIDTH];
                        s1_q[i].cls <= cls_d[i];
                        s1_q[i].sh  <= sh_d[i];
                    end
                end
                if (vld_pipe[1]) out_q <= y;
            end
            if (fire_out) cnt_q <= (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign io.in_ready  = en;
    assign io.out_valid = vld_pipe[STAGES];
    assign io.Out       = out_q;
    assign io.out_last  = vld_pipe[STAGES] && (cnt_q == LAST_BEAT);
    assign io.beat_cnt  = cnt_q;
endmodule

// File: tb/tb_bn_leaky_relu_stage.sv
// Bench for bn_leaky_relu_stage: two instances (SHIFT=3/FRAME_BEATS=4 and SHIFT=1)
// driven with the same stream, checked against a magnitude-based FP16 model.
module tb_bn_leaky_relu_stage;
    localparam int W  = 16;
    localparam int N  = 8;
    localparam int CW = 16;
    typedef logic [W*N-1:0] vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bn_leaky_relu_stage_if #(.DATA_WIDTH(W), .size(N), .CNT_W(CW)) io  ();
    bn_leaky_relu_stage_if #(.DATA_WIDTH(W), .size(N), .CNT_W(CW)) io1 ();

    bn_leaky_relu_stage #(.DATA_WIDTH(W), .size(N), .SHIFT(3), .FRAME_BEATS(4), .CNT_W(CW)) u_dut (
        .clk(clk), .reset(reset), .io(io.slave));
    bn_leaky_relu_stage #(.DATA_WIDTH(W), .size(N), .SHIFT(1), .FRAME_BEATS(64), .CNT_W(CW)) u_dut1 (
        .clk(clk), .reset(reset), .io(io1.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic          acc, dlv, lst;
    vec_t          o, o1;
    logic [CW-1:0] bc;

    // Reference: scale the magnitude in units of 2^-24, truncate, re-encode.
    function automatic logic [15:0] ref_lane(input int sh, input logic [15:0] v);
        int     e, m, er;
        longint mag;
        e = int'(v[14:10]);
        m = int'(v[9:0]);
        if (!v[15] || e == 31) return v;
        mag = (e == 0) ? longint'(m) : (longint'(1024 + m) << (e - 1));
        mag = mag >> sh;
        if (mag < 1024) return {1'b1, 5'd0, 10'(mag)};
        er = 1;
        while (mag >= (longint'(2048) << (er - 1))) er++;
        return {1'b1, 5'(er), 10'((mag >> (er - 1)) - 1024)};
    endfunction

    function automatic vec_t ref_vec(input int sh, input vec_t v);
        vec_t r;
        for (int i = 0; i < N; i++) r[16*i +: 16] = ref_lane(sh, v[16*i +: 16]);
        return r;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t r;
        for (int i = 0; i < N; i++) r[16*i +: 16] = 16'($urandom());
        return r;
    endfunction

    function automatic vec_t rnd_neg_vec();
        vec_t r;
        for (int i = 0; i < N; i++)
            r[16*i +: 16] = {1'b1, 5'($urandom_range(0, 30)), 10'($urandom())};
        return r;
    endfunction

    // Drive one cycle on both instances; sample at the falling edge.
    task automatic cycle(input logic iv, input vec_t xv, input logic ordy);
        io.in_valid  = iv;  io.x  = xv; io.out_ready  = ordy;
        io1.in_valid = iv;  io1.x = xv; io1.out_ready = ordy;
        @(negedge clk);
        acc = iv && io.in_ready;
        dlv = io.out_valid && ordy;
        o   = io.Out;
        o1  = io1.Out;
        bc  = io.beat_cnt;
        lst = io.out_last;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_tests++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", io.out_valid); end
        n_tests++; if (io.Out !== '0) begin n_fail++; $display("FAIL rst_out got %h want 0", io.Out); end
        n_tests++; if (io.beat_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", io.beat_cnt); end
        n_tests++; if (io.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last got %b want 0", io.out_last); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", io.in_ready); end
    endtask

    task automatic test_lanes();
        vec_t vin, want;
        vin  = {16'hFE00, 16'hFC00, 16'h8400, 16'h8000, 16'h0000, 16'hBC00, 16'hC200, 16'h4200};
        want = {16'hFE00, 16'hFC00, 16'h8080, 16'h8000, 16'h0000, 16'hB000, 16'hB600, 16'h4200};
        do_reset();
        cycle(1'b1, vin, 1'b1);
        n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL lanes_accept got %b want 1", acc); end
        cycle(1'b0, '0, 1'b1);
        n_tests++; if (dlv !== 1'b0) begin n_fail++; $display("FAIL lanes_early got %b want 0", dlv); end
        cycle(1'b0, '0, 1'b1);
        n_tests++; if (dlv !== 1'b1) begin n_fail++; $display("FAIL lanes_latency got %b want 1", dlv); end
        n_tests++; if (o !== want) begin n_fail++; $display("FAIL lanes_out got %h want %h", o, want); end
        n_tests++; if (o1 !== ref_vec(1, vin)) begin n_fail++; $display("FAIL lanes_out_s1 got %h want %h", o1, ref_vec(1, vin)); end
        n_tests++; if (bc !== 16'd0) begin n_fail++; $display("FAIL lanes_cnt got %0d want 0", bc); end
        n_tests++; if (lst !== 1'b0) begin n_fail++; $display("FAIL lanes_last got %b want 0", lst); end
    endtask

    task automatic test_back_to_back();
        vec_t vin;
        int   got;
        vin = {64'h4200_4200_4400_4500, 64'h4200_4200_4400_4500};
        got = 0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            cycle(k < 10, vin, 1'b1);
            if (k < 10) begin
                n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL b2b_ready k=%0d got %b want 1", k, acc); end
            end
            if (dlv) begin
                n_tests++; if (o !== vin) begin n_fail++; $display("FAIL b2b_out got %h want %h", o, vin); end
                n_tests++; if (bc !== 16'(got % 4)) begin n_fail++; $display("FAIL b2b_cnt got %0d want %0d", bc, got % 4); end
                got++;
            end
        end
        n_tests++; if (got != 10) begin n_fail++; $display("FAIL b2b_count got %0d want 10", got); end
    endtask

    task automatic test_backpressure();
        vec_t          q[$];
        vec_t          cur, hold_o, exp_v;
        logic [CW-1:0] hold_bc;
        logic          ordy;
        int            sent, got;
        sent = 0; got = 0; hold_o = '0; hold_bc = '0;
        cur = rnd_vec(); cur[15:0] = 16'h3C00;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            ordy = !(c >= 6 && c < 11);
            cycle(sent < 14, cur, ordy);
            if (acc) begin
                q.push_back(cur);
                sent++;
                cur = rnd_vec(); cur[15:0] = 16'h3C00 + 16'(sent);
            end
            if (!ordy) begin
                n_tests++; if (acc !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c=%0d got %b want 0", c, acc); end
                if (c > 6) begin
                    n_tests++; if (o !== hold_o) begin n_fail++; $display("FAIL bp_out_stable got %h want %h", o, hold_o); end
                    n_tests++; if (bc !== hold_bc) begin n_fail++; $display("FAIL bp_cnt_stable got %0d want %0d", bc, hold_bc); end
                end
                hold_o = o; hold_bc = bc;
            end
            if (dlv) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra got %h want none", o);
                end else begin
                    exp_v = ref_vec(3, q.pop_front());
                    if (o !== exp_v) begin n_fail++; $display("FAIL bp_seq got %h want %h", o, exp_v); end
                end
                n_tests++; if (bc !== 16'(got % 4)) begin n_fail++; $display("FAIL bp_cnt got %0d want %0d", bc, got % 4); end
                got++;
            end
        end
        n_tests++; if (got != 14 || q.size() != 0) begin n_fail++; $display("FAIL bp_total got %0d left %0d want 14 left 0", got, q.size()); end
    endtask

    task automatic test_frame();
        int got;
        got = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            cycle(c < 9, rnd_vec(), 1'b1);
            if (dlv) begin
                n_tests++; if (bc !== 16'(got % 4)) begin n_fail++; $display("FAIL frame_cnt beat=%0d got %0d want %0d", got, bc, got % 4); end
                n_tests++; if (lst !== (got % 4 == 3)) begin n_fail++; $display("FAIL frame_last beat=%0d got %b want %b", got, lst, got % 4 == 3); end
                got++;
            end
        end
        n_tests++; if (got != 9) begin n_fail++; $display("FAIL frame_count got %0d want 9", got); end
    endtask

    task automatic test_reset_midframe();
        vec_t v;
        int   got;
        do_reset();
        for (int c = 0; c < 4; c++) cycle(1'b1, rnd_vec(), 1'b1);
        n_tests++; if (io.beat_cnt !== 16'd2 || io.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre got cnt %0d vld %b want 2 1", io.beat_cnt, io.out_valid); end
        reset = 1'b0;
        cycle(1'b0, '0, 1'b0);
        reset = 1'b1;
        n_tests++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", io.out_valid); end
        n_tests++; if (io.Out !== '0) begin n_fail++; $display("FAIL mid_out got %h want 0", io.Out); end
        n_tests++; if (io.beat_cnt !== '0) begin n_fail++; $display("FAIL mid_cnt got %0d want 0", io.beat_cnt); end
        v = rnd_neg_vec();
        got = 0;
        cycle(1'b1, v, 1'b1);
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, '0, 1'b1);
            if (dlv) begin
                n_tests++; if (bc !== 16'd0) begin n_fail++; $display("FAIL mid_first_cnt got %0d want 0", bc); end
                n_tests++; if (o !== ref_vec(3, v)) begin n_fail++; $display("FAIL mid_first_out got %h want %h", o, ref_vec(3, v)); end
                got++;
            end
        end
        n_tests++; if (got != 1) begin n_fail++; $display("FAIL mid_deliveries got %0d want 1", got); end
    endtask

    task automatic test_random();
        vec_t q[$];
        vec_t cur, v;
        int   got;
        got = 0;
        cur = rnd_neg_vec();
        do_reset();
        for (int c = 0; c < 44; c++) begin
            cycle(c < 40, cur, 1'b1);
            if (acc) begin q.push_back(cur); cur = rnd_neg_vec(); end
            if (dlv && q.size() > 0) begin
                v = q.pop_front();
                n_tests++; if (o !== ref_vec(3, v)) begin n_fail++; $display("FAIL rnd_s3 in %h got %h want %h", v, o, ref_vec(3, v)); end
                n_tests++; if (o1 !== ref_vec(1, v)) begin n_fail++; $display("FAIL rnd_s1 in %h got %h want %h", v, o1, ref_vec(1, v)); end
                got++;
            end
        end
        n_tests++; if (got != 40) begin n_fail++; $display("FAIL rnd_count got %0d want 40", got); end
    endtask

    initial begin
        io.in_valid = 1'b0;  io.x  = '0; io.out_ready  = 1'b0;
        io1.in_valid = 1'b0; io1.x = '0; io1.out_ready = 1'b0;
        test_reset();
        test_lanes();
        test_back_to_back();
        test_backpressure();
        test_frame();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bn_leaky_relu_stage.md
Name: bn_leaky_relu_stage

Overview:
- Downstream neighbour of the batch-norm stage: consumes the packed FP16 vector produced by Bn_complete and applies YOLOv3 leaky ReLU per lane.
- Slope is a power of two, 2^-SHIFT (0.125 by default), implemented by exponent adjustment rather than a multiplier.
- Adds a valid/ready handshake, a 2-stage stallable pipeline and a per-frame beat counter, so the activated vectors can feed the next conv or line-buffer stage with a frame-end marker.

Parameters:
- DATA_WIDTH, 16, lane width: IEEE half precision (1/5/10).
- size, 8, number of lanes in the packed vector.
- SHIFT, 3, negative slope = 2^-SHIFT; legal range 1..10.
- FRAME_BEATS, 64, vectors per feature-map tile; out_last marks the final one.
- CNT_W, 16, width of beat_cnt; FRAME_BEATS must be <= 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  x holds a valid vector.
- in_ready  output  1  stage accepts x this cycle.
- x  input  DATA_WIDTH*size  packed FP16 lanes from batch norm; lane i is x[16i+15:16i].
- out_valid  output  1  Out holds a valid vector.
- out_ready  input  1  consumer accepts Out this cycle.
- Out  output  DATA_WIDTH*size  packed activated lanes, same lane order as x.
- out_last  output  1  qualifies Out as the last vector of the frame.
- beat_cnt  output  CNT_W  index of the vector currently on Out within its frame.

Behaviour:
- Reset: while reset==0 at a rising edge, clear all stage valids, Out, out_last and beat_cnt to 0. in_ready reads 1 in the first cycle after reset is released. A reset mid-frame discards any in-flight vectors with no output.
- Pipeline:
  - S1 registers lane classification and partial results; S2 is the output register.
  - Global advance en = !out_valid | out_ready, and in_ready = en.
  - A transfer occurs on in_valid & in_ready. A vector accepted at edge N is on Out after edge N+1.
  - Throughput is 1 vector/cycle with out_ready held high.
  - When en==0, S1 and S2 hold their values; Out and out_last stay stable while out_valid & !out_ready.
  - A bubble (no input transfer while en==1) propagates as an invalid stage, not as a repeated vector.
- Lane function for sign s, exponent e, mantissa m:
  - s==0: pass unchanged.
  - e==31 (Inf/NaN): pass unchanged, so -Inf stays -Inf and NaN keeps its payload.
  - s==1, e==0, m==0: pass as -0 (0x8000).
  - s==1, e>SHIFT: output {1, e-SHIFT, m}.
  - s==1, 1<=e<=SHIFT: output subnormal {1, 5'd0, ({1,m} >> (SHIFT-e+1))[9:0]}, with truncation (no rounding).
  - s==1, e==0, m!=0 (subnormal): output {1, 5'd0, m >> SHIFT}, truncated. A result of 0 gives 0x8000.
- Frame counter:
  - beat_cnt increments on each out_valid & out_ready handshake.
  - out_last = out_valid & (beat_cnt == FRAME_BEATS-1).
  - On the last handshake beat_cnt wraps to 0.
  - The counter holds while out_valid is low or the output is stalled.
- Simultaneous accept and deliver in one cycle is legal and loses no vector.
- No internal FIFO: total storage is 2 vectors.
- Behaviour for an in_valid drop without a handshake is unconstrained; x is not sampled.

Test Plan:
1. Reset, then stream 8 lanes with out_ready=1. Input lanes are 0x4200, 0xC200, 0xBC00, 0x0000, 0x8000, 0x8400, 0xFC00, 0xFE00. Required outputs: 0x4200, 0xB600, 0xB000, 0x0000, 0x8000, 0x8080, 0xFC00, 0xFE00. The vector appears after accept edge N+1.
2. Drive the upstream pattern x = {0x4200,0x4200,0x4400,0x4500} repeated, all positive, for 10 back-to-back beats -> Out equals x every cycle, in_ready constantly 1, and exactly 10 out handshakes.
3. Backpressure: hold out_ready=0 for 5 cycles mid-stream -> in_ready drops once both stages are full, Out and beat_cnt stay stable, and after release no vector is lost or duplicated (sequence checked by tagging lane 0 with 0x3C00+k).
4. Frame marker with FRAME_BEATS=4 over 9 beats -> out_last is high on beats 3 and 7, and beat_cnt sequence is 0,1,2,3,0,1,2,3,0.
5. Assert reset==0 for 1 cycle with 2 vectors in flight and beat_cnt=2 -> next cycle out_valid=0, Out=0, beat_cnt=0, and the first post-reset vector gets beat_cnt 0.
6. Random negative normals against a reference model using truncation, with SHIFT=1 and SHIFT=3 -> bit-exact match on all lanes.
